// File: rtl/event_tx.sv
// event_tx: producer side of the snn_event_if handshake toward the convolution core.
//
// Spike coordinates from the capture stream are buffered in a FIFO. One event
// at a time is moved into an output register and held there until the core
// acknowledges it. After each acknowledge, event_valid stays low for one cycle
// so the consumer cannot take the same event twice. Occupancy is reported
// (excluding the presented event), and events lost to a full buffer are counted.
//
// Optional feature, enabled by defining EVENT_TX_BOUNDS_CHECK_EN:
//   coordinates outside the image (x >= IMG_WIDTH or y >= IMG_HEIGHT) are
//   discarded at the input. They count in drop_count but do not set overflow.

package event_tx_pkg;

    localparam int DEFAULT_COORD_BITS = 8;
    localparam int DEFAULT_IMG_WIDTH  = 32;
    localparam int DEFAULT_IMG_HEIGHT = 32;

    // Coordinate pair as seen on event_coord at the default width, x in the upper half.
    typedef struct packed {
        logic [DEFAULT_COORD_BITS-1:0] x;
        logic [DEFAULT_COORD_BITS-1:0] y;
    } vec2_t;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PRESENT = 2'd1,
        ST_HOLDOFF = 2'd2
    } tx_state_e;

endpackage

module event_tx
    import event_tx_pkg::*;
#(
    parameter int COORD_BITS = DEFAULT_COORD_BITS,
    parameter int IMG_WIDTH  = DEFAULT_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEFAULT_IMG_HEIGHT,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [COORD_BITS-1:0]         in_x,
    input  logic [COORD_BITS-1:0]         in_y,
    output logic                          in_ready,
    input  logic                          flush,
    output logic                          event_valid,
    output logic [2*COORD_BITS-1:0]       event_coord,
    input  logic                          event_ack,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [15:0]                   drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [15:0]   DROP_MAX  = 16'hFFFF;

    // Same {x,y} layout as vec2_t, but sized by this instance's COORD_BITS.
    typedef struct packed {
        logic [COORD_BITS-1:0] x;
        logic [COORD_BITS-1:0] y;
    } coord_t;

    // Buffer storage and bookkeeping
    coord_t        fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_q,   drop_d;

    // Presentation FSM and its registered outputs
    tx_state_e     state_q;
    logic          event_valid_q;
    coord_t        event_coord_q;

    // Per-cycle decisions
    coord_t        in_coord;
    logic          in_bounds;
    logic          push;
    logic          pop;
    logic          ovf_drop;
    logic          bnd_drop;
    logic          drop_inc;

    assign in_coord.x = in_x;
    assign in_coord.y = in_y;

`ifdef EVENT_TX_BOUNDS_CHECK_EN
    assign in_bounds = (32'(in_x) < 32'(IMG_WIDTH)) && (32'(in_y) < 32'(IMG_HEIGHT));
`else
    // Without filtering every coordinate is in range; the image extents are not consulted.
    logic unused_bounds;
    assign unused_bounds = (IMG_WIDTH > 0) ^ (IMG_HEIGHT > 0);
    assign in_bounds     = 1'b1;
`endif

    // Ready depends only on the registered count, so a pop this cycle cannot
    // make room for a push in the same cycle.
    assign in_ready = (count_q < DEPTH_C);

    // A full buffer loses the event and flags overflow.
    assign ovf_drop = in_valid && !in_ready;

    // An out-of-image coordinate is filtered without touching overflow.
    assign bnd_drop = in_valid && in_ready && !in_bounds;

    // Flush wins over everything arriving in the same cycle: no write, no count.
    assign push     = in_valid && in_ready && in_bounds && !flush;
    assign drop_inc = (ovf_drop || bnd_drop) && !flush;

    // The FSM pulls the head whenever it is not holding an event and data waits.
    assign pop      = !flush && (state_q != ST_PRESENT) && (count_q != '0);

    // Next-state for pointers, occupancy and drop bookkeeping
    always_comb begin
        // NOTE: every target of this block is defaulted first so no latch is inferred.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            // Pointers are exactly AW bits wide, so the increment wraps modulo FIFO_DEPTH.
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end

            // Push and pop together leave the occupancy unchanged.
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

            if (ovf_drop) begin
                overflow_d = 1'b1;
            end

            if (drop_inc && (drop_q != DROP_MAX)) begin
                drop_d = drop_q + 16'd1;
            end
        end
    end

    // Bookkeeping registers
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Buffer write port
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; an entry is only read after the count says it was written.
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= in_coord;
        end
    end

    // Presentation FSM: load the head, hold it until acked, then one idle cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_EMPTY;
            event_valid_q <= 1'b0;
            event_coord_q <= '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    // Flush here simply keeps the FSM empty: pop is already blocked.
                    if (pop) begin
                        event_coord_q <= fifo_mem_q[rd_ptr_q];
                        event_valid_q <= 1'b1;
                        state_q       <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    // Flush does not disturb the presented event; only the ack releases it.
                    if (event_ack) begin
                        event_valid_q <= 1'b0;
                        state_q       <= ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    if (pop) begin
                        event_coord_q <= fifo_mem_q[rd_ptr_q];
                        event_valid_q <= 1'b1;
                        state_q       <= ST_PRESENT;
                    end else begin
                        state_q       <= ST_EMPTY;
                    end
                end
                default: begin
                    event_valid_q <= 1'b0;
                    state_q       <= ST_EMPTY;
                end
            endcase
        end
    end

    assign event_valid = event_valid_q;
    assign event_coord = event_coord_q;
    assign fifo_count  = count_q;
    assign overflow    = overflow_q;
    assign drop_count  = drop_q;

endmodule

// File: doc/event_tx.md
# event_tx

Event transmitter: the producer side of the `snn_event_if` handshake that feeds the convolution core.
- Accepts spike coordinates from the upstream capture stream and buffers them in a FIFO.
- Presents one event at a time to the convolution, holding it stable until the core acknowledges it.
- Reports occupancy and counts events dropped on overflow.

## Interface
Parameters:
- COORD_BITS, DEFAULT_COORD_BITS: width of each coordinate component.
- IMG_WIDTH, DEFAULT_IMG_WIDTH: valid x range 0..IMG_WIDTH-1.
- IMG_HEIGHT, DEFAULT_IMG_HEIGHT: valid y range 0..IMG_HEIGHT-1.
- FIFO_DEPTH, 16: buffer entries; must be a power of 2, ≥2.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream event present.
- in_x  in  COORD_BITS  upstream x.
- in_y  in  COORD_BITS  upstream y.
- in_ready  out  1  FIFO can accept (count < FIFO_DEPTH).
- flush  in  1  synchronous clear of buffered events and counters.
- event_valid  out  1  to the convolution: event presented.
- event_coord  out  vec2_t  to the convolution: presented {x,y}.
- event_ack  in  1  from the convolution: one-cycle acknowledge.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO entries, excluding the presented event.
- overflow  out  1  sticky: at least one event was dropped.
- drop_count  out  16  saturating count of dropped events.

## Operation
- Push: in_valid && in_ready writes {in_x,in_y} to the FIFO tail at the rising edge.
- Drop: in_valid && !in_ready discards the event, sets overflow, and increments drop_count, saturating at 0xFFFF.
- in_ready is derived from the registered count only. A pop in the same cycle does not free a slot for that cycle's push.
- Output register: the presented event sits outside the FIFO. Total capacity is FIFO_DEPTH+1.
- FSM states: EMPTY, PRESENT, HOLDOFF.
  - EMPTY: event_valid=0. If fifo_count>0, pop the head into event_coord, then go to PRESENT.
  - PRESENT: event_valid=1 and event_coord held stable. On event_ack=1, go to HOLDOFF.
  - HOLDOFF: event_valid=0 for exactly one cycle, so the consumer cannot capture the same event twice. If fifo_count>0, pop the head and go to PRESENT; else go to EMPTY.
- event_ack is ignored in EMPTY and HOLDOFF.
- A push and a pop in the same cycle leave fifo_count unchanged. Both pointers wrap modulo FIFO_DEPTH.
- flush:
  - Empties the FIFO (pointers and count cleared).
  - Clears overflow and drop_count.
  - In PRESENT, the presented event stays valid until acked, so the handshake is never broken. In any other state, the FSM goes to EMPTY.
  - A push in the same cycle as flush is discarded and not counted.
- Reset values: event_valid=0, event_coord={0,0}, in_ready=1, fifo_count=0, overflow=0, drop_count=0, state=EMPTY.
- Reset asserted mid-handshake immediately forces event_valid low and discards all buffered events.

## Timing
- Latency into an empty block:
  - Event accepted at edge k → event_valid=1 after edge k+1.
- Ack turnaround:
  - event_ack sampled high at edge m → event_valid=0 after edge m.
  - The next buffered event is valid after edge m+1.
- Back-to-back throughput is one event per (consumer ack latency + 2) cycles.
- in_ready falls after the edge at which fifo_count reaches FIFO_DEPTH.
- in_ready rises after the first pop edge that reduces fifo_count below FIFO_DEPTH.

## Configuration
- EVENT_TX_BOUNDS_CHECK_EN defined:
  - A push with in_x ≥ IMG_WIDTH or in_y ≥ IMG_HEIGHT is discarded at the input.
  - It increments drop_count but does not set overflow.
  - in_ready is unaffected.
- Undefined: every coordinate is buffered and forwarded unchanged.

## Test plan
- Single event: reset, push (3,5) at edge 1, ack 2 cycles after valid → event_valid high after edge 2, coord=(3,5), low after the ack edge, returns to EMPTY, fifo_count=0.
- Ordering and holdoff: push (1,1),(2,2),(3,3) back-to-back, ack each → delivered in order; event_valid low for exactly one cycle between events; coords never change while valid.
- Overflow with FIFO_DEPTH=4 and no ack: push 7 events → 1 presented plus 4 buffered; in_ready=0; drop_count=2; overflow=1; after one ack, in_ready=1 one edge after the HOLDOFF pop.
- Flush while PRESENT with 3 buffered: assert flush → fifo_count=0, drop_count=0, overflow=0, presented event still valid; after ack, state=EMPTY.
- Async reset mid-PRESENT: drop reset between edges → event_valid=0 and fifo_count=0 immediately, without waiting for a clock edge.
- Bounds (EVENT_TX_BOUNDS_CHECK_EN, IMG_WIDTH=32): push (32,0) then (31,0) → only (31,0) presented; drop_count=1; overflow=0.
